// File: rtl/mem_ctrl.sv
// mem_ctrl: shares one byte-wide RAM port between instruction fetch and load/store,
// moving multi-byte transfers one byte per cycle and stalling the requester meanwhile.
module mem_ctrl #(
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_inst,
    output logic              if_stallreq,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_stallreq,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_MEM = 1'b1;

    logic [1:0]        state;
    logic              owner;
    logic              we;
    logic [ADDR_W-1:0] base;
    logic [2:0]        cnt;
    logic [2:0]        len;
    logic [31:0]       wdata;
    logic [31:0]       result;
    logic [31:0]       assembled;
    logic [ADDR_W-1:0] start_addr;
    logic [2:0]        start_len;
    logic [2:0]        cnt_next;
    logic [1:0]        byte_sel;
    logic              start_store;
    logic              unused_addr_bits;

    // MEM wins when both stages ask in the same cycle
    assign start_addr  = mem_req ? mem_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
    assign start_store = mem_req & mem_we;
    assign cnt_next    = cnt + 3'd1;
    assign byte_sel    = cnt[1:0] - 2'd1;

    assign unused_addr_bits = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

    always_comb begin
        start_len = 3'd4;
        if (mem_req) begin
            case (mem_size)
                2'd0:    start_len = 3'd1;
                2'd1:    start_len = 3'd2;
                default: start_len = 3'd4;
            endcase
        end
    end

    // RAM read data lags its address by a cycle, so count cnt lands in byte cnt-1
    always_comb begin
        assembled = result;
        assembled[{byte_sel, 3'b000} +: 8] = ram_din;
    end

    assign if_stallreq  = rst & if_req  & ~((state == DONE) && (owner == OWNER_IF));
    assign mem_stallreq = rst & mem_req & ~((state == DONE) && (owner == OWNER_MEM));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            owner     <= OWNER_IF;
            we        <= 1'b0;
            base      <= '0;
            cnt       <= 3'd0;
            len       <= 3'd0;
            wdata     <= 32'd0;
            result    <= 32'd0;
            ram_addr  <= '0;
            ram_wr    <= 1'b0;
            ram_dout  <= 8'd0;
            if_inst   <= 32'd0;
            mem_rdata <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_req | if_req) begin
                        state    <= BUSY;
                        owner    <= mem_req;
                        we       <= start_store;
                        base     <= start_addr;
                        len      <= start_len;
                        wdata    <= mem_wdata;
                        cnt      <= 3'd0;
                        result   <= 32'd0;
                        ram_addr <= start_addr;
                        ram_wr   <= start_store;
                        if (start_store) begin
                            ram_dout <= mem_wdata[7:0];
                        end
                    end
                end
                BUSY: begin
                    cnt <= cnt_next;
                    if (we) begin
                        if (cnt_next == len) begin
                            ram_wr <= 1'b0;
                            state  <= DONE;
                        end else begin
                            ram_addr <= base + ADDR_W'(cnt_next);
                            ram_dout <= wdata[{cnt_next[1:0], 3'b000} +: 8];
                        end
                    end else begin
                        if (cnt != 3'd0) begin
                            result <= assembled;
                        end
                        if (cnt_next < len) begin
                            ram_addr <= base + ADDR_W'(cnt_next);
                        end
                        if (cnt == len) begin
                            state <= DONE;
                            if (owner == OWNER_MEM) begin
                                mem_rdata <= assembled;
                            end else begin
                                if_inst <= assembled;
                            end
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed bench for mem_ctrl with a byte RAM, a transaction-level model
// checked on every cycle, and hand-computed literal expectations per scenario.
module tb_mem_ctrl;

    localparam int ADDR_W   = 17;
    localparam int RAM_SIZE = 1 << ADDR_W;
    localparam int TIMEOUT  = 60;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req = 1'b0;
    logic [31:0]       if_addr = 32'd0;
    logic [31:0]       if_inst;
    logic              if_stallreq;
    logic              mem_req = 1'b0;
    logic              mem_we = 1'b0;
    logic [1:0]        mem_size = 2'd0;
    logic [31:0]       mem_addr = 32'd0;
    logic [31:0]       mem_wdata = 32'd0;
    logic [31:0]       mem_rdata;
    logic              mem_stallreq;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;

    logic [7:0] ram    [0:RAM_SIZE-1];
    logic [7:0] shadow [0:RAM_SIZE-1];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    mem_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_inst      (if_inst),
        .if_stallreq  (if_stallreq),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_stallreq (mem_stallreq),
        .ram_addr     (ram_addr),
        .ram_wr       (ram_wr),
        .ram_dout     (ram_dout),
        .ram_din      (ram_din)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_din <= ram[ram_addr];
        if (ram_wr) ram[ram_addr] <= ram_dout;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
        ram[a]    <= d;
        shadow[a] = d;
    endtask

    function automatic int bytes_for(input logic [1:0] s);
        case (s)
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    // Transfer model: a transfer seen in a free cycle owns the port for its byte count
    // (+1 for the read latency on loads) and then reports completion for one cycle.
    logic              m_active = 1'b0;
    logic              m_own_mem = 1'b0;
    logic              m_we = 1'b0;
    int                m_start = 0;
    int                m_done = 0;
    int                m_n = 0;
    logic [ADDR_W-1:0] m_base = '0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [31:0]       m_wdata = 32'd0;
    logic [31:0]       m_result = 32'd0;
    logic [31:0]       m_ifinst = 32'd0;
    logic [31:0]       m_rdata = 32'd0;

    always @(negedge clk) begin
        logic [31:0] a;
        logic [31:0] sh;
        logic        exp_wr;
        logic        exp_if;
        logic        exp_mem;
        logic        done_now;
        logic [7:0]  exp_dout;
        int          k;
        cyc = cyc + 1;
        if (!rst) begin
            m_active = 1'b0;
            m_done   = cyc;
            m_addr   = '0;
            m_ifinst = 32'd0;
            m_rdata  = 32'd0;
            checkOutput("rst_if_stallreq", 32'(if_stallreq), 32'd0);
            checkOutput("rst_mem_stallreq", 32'(mem_stallreq), 32'd0);
            checkOutput("rst_ram_addr", 32'(ram_addr), 32'd0);
            checkOutput("rst_ram_wr", 32'(ram_wr), 32'd0);
            checkOutput("rst_ram_dout", 32'(ram_dout), 32'd0);
            checkOutput("rst_if_inst", if_inst, 32'd0);
            checkOutput("rst_mem_rdata", mem_rdata, 32'd0);
        end else begin
            if (cyc > m_done) begin
                m_active = mem_req | if_req;
                if (m_active) begin
                    m_own_mem = mem_req;
                    m_start   = cyc;
                    m_n       = m_own_mem ? bytes_for(mem_size) : 4;
                    m_we      = m_own_mem & mem_we;
                    a         = m_own_mem ? mem_addr : if_addr;
                    m_base    = a[ADDR_W-1:0];
                    m_wdata   = mem_wdata;
                    m_done    = cyc + (m_we ? m_n : m_n + 1) + 1;
                    m_result  = 32'd0;
                    if (!m_we) begin
                        for (int i = 0; i < m_n; i++) begin
                            m_result = m_result |
                                (32'(shadow[m_base + ADDR_W'(i)]) << (8 * i));
                        end
                    end
                end
            end
            exp_wr   = 1'b0;
            exp_dout = 8'd0;
            done_now = m_active && (cyc == m_done);
            if (m_active && cyc > m_start && cyc < m_done) begin
                k = cyc - m_start - 1;
                if (m_we) begin
                    exp_wr   = 1'b1;
                    m_addr   = m_base + ADDR_W'(k);
                    sh       = m_wdata >> (8 * k);
                    exp_dout = sh[7:0];
                end else begin
                    m_addr = m_base + ADDR_W'((k < m_n) ? k : m_n - 1);
                end
            end
            if (done_now && !m_we) begin
                if (m_own_mem) m_rdata = m_result;
                else           m_ifinst = m_result;
            end
            exp_if  = if_req  && !(done_now && !m_own_mem);
            exp_mem = mem_req && !(done_now && m_own_mem);
            checkOutput("if_stallreq", 32'(if_stallreq), 32'(exp_if));
            checkOutput("mem_stallreq", 32'(mem_stallreq), 32'(exp_mem));
            checkOutput("ram_wr", 32'(ram_wr), 32'(exp_wr));
            checkOutput("ram_addr", 32'(ram_addr), 32'(m_addr));
            checkOutput("if_inst", if_inst, m_ifinst);
            checkOutput("mem_rdata", mem_rdata, m_rdata);
            if (exp_wr) begin
                checkOutput("ram_dout", 32'(ram_dout), 32'(exp_dout));
                shadow[m_addr] = exp_dout;
            end
        end
    end

    // Acts as the requesting stage: holds its request until the pipeline would accept
    // (a fetch is only accepted when the load/store stage is not stalling as well).
    task automatic applyStimulus(input logic is_mem, input logic we, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output int high, output int drops);
        logic accepted;
        accepted = 1'b0;
        high     = 0;
        drops    = 0;
        if (is_mem) begin
            mem_req   = 1'b1;
            mem_we    = we;
            mem_size  = size;
            mem_addr  = addr;
            mem_wdata = wdata;
        end else begin
            if_req  = 1'b1;
            if_addr = addr;
        end
        for (int c = 0; c < TIMEOUT && !accepted; c++) begin
            @(negedge clk);
            if (is_mem ? mem_stallreq : if_stallreq) begin
                high++;
            end else begin
                drops++;
                accepted = is_mem ? 1'b1 : !mem_stallreq;
            end
        end
        checkOutput(is_mem ? "mem_completed" : "if_completed", 32'(accepted), 32'd1);
        @(posedge clk);
        #1;
        if (is_mem) mem_req = 1'b0;
        else        if_req  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int hi, dr, mh, md;
        preload(17'h00010, 8'h13);
        preload(17'h00011, 8'h57);
        preload(17'h00012, 8'h9B);
        preload(17'h00013, 8'hDF);
        preload(17'h00020, 8'h11);
        preload(17'h00021, 8'h22);
        preload(17'h00022, 8'h33);
        preload(17'h00023, 8'h44);
        preload(17'h00030, 8'h66);
        preload(17'h00031, 8'h77);
        preload(17'h00040, 8'h00);
        preload(17'h00041, 8'h00);
        preload(17'h00042, 8'h00);
        preload(17'h00043, 8'h00);
        preload(17'h00060, 8'hAA);
        preload(17'h00061, 8'hBB);
        preload(17'h00062, 8'hCC);
        preload(17'h00063, 8'hDD);
        preload(17'h1FFFF, 8'h5A);
        preload(17'h00000, 8'h01);
        preload(17'h00001, 8'h02);
        preload(17'h00002, 8'h03);

        #1 rst = 1'b0;
        mem_we = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if_req  = ~if_req;
            mem_req = ~mem_req;
        end
        checkOutput("rst_hold_if_stall", 32'(if_stallreq), 32'd0);
        checkOutput("rst_hold_mem_stall", 32'(mem_stallreq), 32'd0);
        @(posedge clk);
        #1;
        if_req  = 1'b0;
        mem_req = 1'b0;
        rst     = 1'b1;

        applyStimulus(1'b0, 1'b0, 2'd2, 32'h0000_0010, 32'd0, hi, dr);
        checkOutput("fetch_inst", if_inst, 32'hDF9B5713);
        checkOutput("fetch_stall_len", hi, 32'd6);

        applyStimulus(1'b1, 1'b1, 2'd1, 32'h0000_0020, 32'h1234_BEEF, mh, md);
        checkOutput("sh_stall_len", mh, 32'd3);
        checkOutput("sh_byte0", 32'(ram[17'h00020]), 32'h0000_00EF);
        checkOutput("sh_byte1", 32'(ram[17'h00021]), 32'h0000_00BE);
        checkOutput("sh_byte2_kept", 32'(ram[17'h00022]), 32'h0000_0033);

        applyStimulus(1'b1, 1'b0, 2'd0, 32'h0000_0021, 32'd0, mh, md);
        checkOutput("lb_data", mem_rdata, 32'h0000_00BE);
        checkOutput("lb_stall_len", mh, 32'd3);

        applyStimulus(1'b1, 1'b1, 2'd2, 32'h0000_0020, 32'h8000_0001, mh, md);
        checkOutput("sw_stall_len", mh, 32'd5);
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h0000_0020, 32'd0, mh, md);
        checkOutput("lw_data", mem_rdata, 32'h8000_0001);
        checkOutput("lw_stall_len", mh, 32'd6);

        applyStimulus(1'b1, 1'b1, 2'd0, 32'h0000_0030, 32'hFFFF_FFA5, mh, md);
        checkOutput("sb_stall_len", mh, 32'd2);
        checkOutput("sb_byte0", 32'(ram[17'h00030]), 32'h0000_00A5);
        checkOutput("sb_byte1_kept", 32'(ram[17'h00031]), 32'h0000_0077);

        // size 3 is a word; address wraps from the top of RAM to 0
        applyStimulus(1'b1, 1'b0, 2'd3, 32'hFFFF_FFFF, 32'd0, mh, md);
        checkOutput("wrap_lw_data", mem_rdata, 32'h0302_015A);
        checkOutput("wrap_lw_stall_len", mh, 32'd6);

        fork
            applyStimulus(1'b1, 1'b1, 2'd2, 32'h0000_0040, 32'hCAFE_F00D, mh, md);
            applyStimulus(1'b0, 1'b0, 2'd2, 32'h0000_0040, 32'd0, hi, dr);
        join
        checkOutput("prio_mem_stall_len", mh, 32'd5);
        checkOutput("prio_if_stall_len", hi, 32'd12);
        checkOutput("prio_if_drops", dr, 32'd1);
        checkOutput("prio_if_inst", if_inst, 32'hCAFE_F00D);

        applyStimulus(1'b0, 1'b0, 2'd2, 32'h0000_0010, 32'd0, hi, dr);
        checkOutput("b2b_first_stall_len", hi, 32'd6);
        applyStimulus(1'b0, 1'b0, 2'd2, 32'h0000_0040, 32'd0, hi, dr);
        checkOutput("b2b_second_stall_len", hi, 32'd6);
        checkOutput("b2b_if_inst", if_inst, 32'hCAFE_F00D);

        fork
            applyStimulus(1'b0, 1'b0, 2'd2, 32'h0000_0010, 32'd0, hi, dr);
            begin
                repeat (2) @(posedge clk);
                #1;
                applyStimulus(1'b1, 1'b0, 2'd2, 32'h0000_0020, 32'd0, mh, md);
            end
        join
        checkOutput("coll_if_stall_len", hi, 32'd19);
        checkOutput("coll_if_drops", dr, 32'd2);
        checkOutput("coll_mem_stall_len", mh, 32'd11);
        checkOutput("coll_if_inst", if_inst, 32'hDF9B5713);
        checkOutput("coll_mem_rdata", mem_rdata, 32'h8000_0001);

        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_size  = 2'd2;
        mem_addr  = 32'h0000_0060;
        mem_wdata = 32'h5566_7788;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("abort_ram_wr", 32'(ram_wr), 32'd0);
        checkOutput("abort_mem_stall", 32'(mem_stallreq), 32'd0);
        @(posedge clk);
        #1 mem_req = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        checkOutput("abort_byte0", 32'(ram[17'h00060]), 32'h0000_0088);
        checkOutput("abort_byte1", 32'(ram[17'h00061]), 32'h0000_0077);
        checkOutput("abort_byte2", 32'(ram[17'h00062]), 32'h0000_00CC);
        checkOutput("abort_byte3", 32'(ram[17'h00063]), 32'h0000_00DD);
        applyStimulus(1'b1, 1'b0, 2'd2, 32'h0000_0060, 32'd0, mh, md);
        checkOutput("post_abort_lw", mem_rdata, 32'hDDCC_7788);
        checkOutput("post_abort_stall_len", mh, 32'd6);

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Arbitrates the instruction-fetch and load/store stages onto the single byte-wide RAM port.
- Sequences multi-byte transfers one byte per cycle.
- Raises if_stallreq / mem_stallreq toward the pipeline stall controller until each transfer completes.
- It is the requester side of the stall protocol: it produces the stall requests that the stall controller turns into the stall vector.

Parameters:
ADDR_W, 17, RAM byte-address width; ram_addr = low ADDR_W bits of (base + byte index), wraps modulo 2^ADDR_W.

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-low reset
if_req  in  1  fetch request, held stable while stalled
if_addr  in  32  fetch byte address
if_inst  out  32  fetched word, little-endian, registered
if_stallreq  out  1  fetch not yet complete
mem_req  in  1  load/store request, held stable while stalled
mem_we  in  1  1 = store, 0 = load
mem_size  in  2  0 = byte, 1 = half, 2 = word (3 treated as word)
mem_addr  in  32  data byte address
mem_wdata  in  32  store data; bytes taken from the LSB up
mem_rdata  out  32  load data, zero-extended, registered
mem_stallreq  out  1  load/store not yet complete
ram_addr  out  ADDR_W  RAM byte address
ram_wr  out  1  RAM write strobe
ram_dout  out  8  RAM write byte
ram_din  in  8  RAM read byte; valid one cycle after its address is driven

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, cnt=0.
  - ram_addr, ram_wr, ram_dout, if_inst and mem_rdata all 0.
  - Both stallreqs forced to 0 while rst is low.
  - A reset mid-transfer abandons the transfer; RAM bytes already written stay written.
- States:
  - IDLE: in the cycle a request is seen, latch owner, base address, N (1/2/4 bytes; IF always 4), we and wdata; clear cnt; go to BUSY. MEM has priority when both requests are high.
  - BUSY, load: lasts N+1 cycles, cnt = 0..N.
    - For cnt < N, drive ram_addr = base+cnt.
    - For cnt >= 1, capture ram_din into result byte cnt-1.
    - At cnt = N, write the assembled result into if_inst or mem_rdata (upper bytes 0) and go to DONE.
  - BUSY, store: lasts N cycles, cnt = 0..N-1.
    - ram_wr = 1, ram_addr = base+cnt, ram_dout = wdata[8cnt+7:8cnt].
    - After cnt = N-1, go to DONE.
  - DONE: exactly 1 cycle; ram_wr = 0; then IDLE.
- ram_wr is high only in store BUSY cycles.
- ram_addr holds its last value when idle.
- Stall requests (combinational from registered state and inputs):
  - if_stallreq = if_req & ~(state==DONE & owner==IF)
  - mem_stallreq = mem_req & ~(state==DONE & owner==MEM)
  - A requester waiting behind the other owner keeps its stallreq high.
- Stall lengths, counted from the IDLE cycle:
  - word load: stallreq high 6 cycles, low on the 7th
  - byte load: high 3 cycles
  - word store: high 5 cycles
  - byte store: high 2 cycles
- Fetch collision: if an IF transfer reaches DONE while mem_stallreq is high, the pipeline does not accept the word. The IF request, still held, is re-served after the MEM transfer. This is required behaviour, not an error.
- Back-to-back: a request still high in the cycle after DONE is treated as a new transfer.
- No alignment checks; addresses increment bytewise and wrap at 2^ADDR_W.
- Pipeline stall vector is not an input; the requesters guarantee their requests stay stable.

Test Plan:
- Reset: hold rst low, toggle if_req/mem_req -> all outputs 0 and both stallreqs 0; release -> IDLE.
- Word fetch: RAM[0x10..0x13] = 13,57,9B,DF, if_req=1 at 0x10 -> ram_addr 0x10..0x13 on consecutive cycles, if_stallreq high 6 cycles, if_inst = 0xDF9B5713 in the cycle if_stallreq drops.
- Stores and loads: sh 0xBEEF to 0x20 -> two ram_wr cycles writing EF, BE, mem_stallreq high 3 cycles. Then lb from 0x21 -> mem_rdata = 0x000000BE. Then lw from 0x20 after sw 0x80000001 -> 0x80000001.
- Priority: if_req and mem_req rise together -> MEM served first, if_stallreq held high throughout, then IF served. The fetched word equals the RAM contents after the MEM store.
- Collision: IF transfer in BUSY when mem_req rises -> mem_stallreq high until the MEM DONE. The IF fetch completes once, then is re-served, and both final results are correct.
- Async reset mid word store after two bytes -> ram_wr drops immediately, only those 2 bytes changed, next request starts from IDLE.
